// File: rtl/adc_reader_pkg.sv
// Shared register map, field positions and Wishbone FSM states for the ADC sample reader.
package adc_reader_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned STATUS_EMPTY_BIT = 8;
  localparam int unsigned STATUS_FULL_BIT  = 9;
  localparam int unsigned STATUS_OVF_BIT   = 10;
  localparam int unsigned STATUS_EN_BIT    = 11;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_FLUSH_BIT = 1;
  localparam int unsigned CTRL_THR_LSB   = 4;
  localparam int unsigned CTRL_THR_WIDTH = 4;
  localparam int unsigned CTRL_OVS_LSB   = 16;
  localparam int unsigned CTRL_OVS_WIDTH = 10;

  localparam logic [CTRL_OVS_WIDTH-1:0] OVS_RESET = 10'h0FF;

  typedef enum logic {
    StIdle,
    StAck
  } wb_state_e;

  // Threshold of zero disables the interrupt.
  function automatic logic fill_irq(input int unsigned count, input int unsigned thr);
    return (thr != 0) && (count >= thr);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush; flush wins over a same-edge push or pop.
module sync_fifo #(
  parameter int unsigned Width     = 32,
  parameter int unsigned DepthLog2 = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [Width-1:0]     data_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  output logic [Width-1:0]     data_o,
  output logic [DepthLog2:0]   count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned Depth = 1 << DepthLog2;

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DepthLog2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DepthLog2:0]   count_q, count_d;
  logic                 push_en, pop_en;

  assign full_o  = (count_q == (DepthLog2 + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when a pop frees a slot on the same edge.
  assign push_en = push_i & ~flush_i & (~full_o | pop_i);
  assign pop_en  = pop_i & ~flush_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + DepthLog2'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + DepthLog2'(1);
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + (DepthLog2 + 1)'(1);
        2'b01:   count_d = count_q - (DepthLog2 + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/adc_sample_reader.sv
// Wishbone-readable sample buffer for the VCO-ADC, with enable/oversample control and fill irq.
module adc_sample_reader
  import adc_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned OVS_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] adc_data_in,
  input  logic                  adc_valid_in,
  output logic                  adc_enable_out,
  output logic [OVS_WIDTH-1:0]  adc_oversample_out,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  irq_o
);

  localparam int unsigned CntW = DEPTH_LOG2 + 1;

  wb_state_e state_q, state_d;

  logic                  req, rd_req, wr_req;
  logic [1:0]            reg_idx;
  logic [31:0]           rdata;
  logic [31:0]           dat_q, dat_d;
  logic                  en_q, en_d;
  logic [CTRL_THR_WIDTH-1:0] thr_q, thr_d;
  logic [OVS_WIDTH-1:0]  ovs_q, ovs_d;
  logic                  ovf_q, ovf_d;
  logic                  irq_q, irq_d;
  logic                  ovf_set, ovf_clr;

  logic                  fifo_push, fifo_pop, fifo_flush;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [CntW-1:0]       fifo_count;
  logic                  fifo_full, fifo_empty;

  logic                  unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i};

  assign reg_idx = wbs_adr_i[3:2];

  sync_fifo #(
    .Width     (DATA_WIDTH),
    .DepthLog2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (fifo_push),
    .data_i  (adc_data_in),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Registered ack: a request is only accepted while no ack is being driven.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          req     = 1'b1;
          state_d = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign rd_req = req & ~wbs_we_i;
  assign wr_req = req & wbs_we_i;

  always_comb begin
    rdata = '0;
    unique case (reg_idx)
      REG_DATA: begin
        if (!fifo_empty) rdata[DATA_WIDTH-1:0] = fifo_head;
      end
      REG_STATUS: begin
        rdata[CntW-1:0]         = fifo_count;
        rdata[STATUS_EMPTY_BIT] = fifo_empty;
        rdata[STATUS_FULL_BIT]  = fifo_full;
        rdata[STATUS_OVF_BIT]   = ovf_q;
        rdata[STATUS_EN_BIT]    = en_q;
      end
      REG_CTRL: begin
        rdata[CTRL_EN_BIT]                       = en_q;
        rdata[CTRL_THR_LSB +: CTRL_THR_WIDTH]    = thr_q;
        rdata[CTRL_OVS_LSB +: OVS_WIDTH]         = ovs_q;
      end
      default: rdata = '0;
    endcase
  end

  always_comb begin
    en_d       = en_q;
    thr_d      = thr_q;
    ovs_d      = ovs_q;
    fifo_flush = 1'b0;
    ovf_clr    = 1'b0;
    if (wr_req && (reg_idx == REG_CTRL)) begin
      en_d       = wbs_dat_i[CTRL_EN_BIT];
      fifo_flush = wbs_dat_i[CTRL_FLUSH_BIT];
      thr_d      = wbs_dat_i[CTRL_THR_LSB +: CTRL_THR_WIDTH];
      ovs_d      = wbs_dat_i[CTRL_OVS_LSB +: OVS_WIDTH];
    end
    if (wr_req && (reg_idx == REG_STATUS)) begin
      ovf_clr = wbs_dat_i[STATUS_OVF_BIT];
    end
  end

  assign fifo_push = adc_valid_in & en_q;
  assign fifo_pop  = rd_req & (reg_idx == REG_DATA) & ~fifo_empty;

  // A sample lost to a flush is not an overflow; set beats a same-edge clear.
  assign ovf_set = fifo_push & fifo_full & ~fifo_pop & ~fifo_flush;
  assign ovf_d   = ovf_set | (ovf_q & ~ovf_clr);

  assign irq_d = fill_irq(32'(fifo_count), 32'(thr_q));
  assign dat_d = rd_req ? rdata : dat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dat_q   <= '0;
      en_q    <= 1'b0;
      thr_q   <= '0;
      ovs_q   <= OVS_WIDTH'(OVS_RESET);
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      en_q    <= en_d;
      thr_q   <= thr_d;
      ovs_q   <= ovs_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
    end
  end

  assign wbs_ack_o          = (state_q == StAck);
  assign wbs_dat_o          = dat_q;
  assign adc_enable_out     = en_q;
  assign adc_oversample_out = ovs_q;
  assign irq_o              = irq_q;

endmodule

// File: tb/tb_adc_sample_reader.sv
// Directed bench for adc_sample_reader: register access, FIFO edge cases, irq timing and reset.
module tb_adc_sample_reader;

  localparam logic [1:0] RDATA = 2'd0;
  localparam logic [1:0] RSTAT = 2'd1;
  localparam logic [1:0] RCTRL = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] adc_data_in;
  logic        adc_valid_in;
  logic        adc_enable_out;
  logic [9:0]  adc_oversample_out;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        irq_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  adc_sample_reader #(
    .DATA_WIDTH (32),
    .DEPTH_LOG2 (3),
    .OVS_WIDTH  (10)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .adc_data_in        (adc_data_in),
    .adc_valid_in       (adc_valid_in),
    .adc_enable_out     (adc_enable_out),
    .adc_oversample_out (adc_oversample_out),
    .wbs_cyc_i          (wbs_cyc_i),
    .wbs_stb_i          (wbs_stb_i),
    .wbs_we_i           (wbs_we_i),
    .wbs_adr_i          (wbs_adr_i),
    .wbs_dat_i          (wbs_dat_i),
    .wbs_ack_o          (wbs_ack_o),
    .wbs_dat_o          (wbs_dat_o),
    .irq_o              (irq_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One Wishbone transfer; optionally presents an ADC sample on the request edge.
  task automatic wb_xfer(input logic we, input logic [1:0] idx, input logic [31:0] wdata,
                         input logic with_push, input logic [31:0] pdata,
                         output logic [31:0] rdata);
    logic got_ack;
    got_ack   = 1'b0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_we_i  = we;
    wbs_adr_i = {idx, 2'b00};
    wbs_dat_i = wdata;
    if (with_push) begin
      adc_valid_in = 1'b1;
      adc_data_in  = pdata;
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      adc_valid_in = 1'b0;
      if (wbs_ack_o) begin
        got_ack = 1'b1;
        break;
      end
    end
    rdata     = wbs_dat_o;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    check_eq("wb_ack", {31'b0, got_ack}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wb_read(input logic [1:0] idx, output logic [31:0] rdata);
    wb_xfer(1'b0, idx, 32'd0, 1'b0, 32'd0, rdata);
  endtask

  task automatic wb_write(input logic [1:0] idx, input logic [31:0] wdata);
    logic [31:0] dummy;
    wb_xfer(1'b1, idx, wdata, 1'b0, 32'd0, dummy);
  endtask

  task automatic adc_push(input logic [31:0] d);
    adc_valid_in = 1'b1;
    adc_data_in  = d;
    @(posedge clk); #1;
    adc_valid_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    adc_data_in = '0; adc_valid_in = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = '0; wbs_dat_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check_eq("rst_ack", {31'b0, wbs_ack_o}, 32'd0);
    check_eq("rst_dat", wbs_dat_o, 32'd0);
    check_eq("rst_irq", {31'b0, irq_o}, 32'd0);
    check_eq("rst_en", {31'b0, adc_enable_out}, 32'd0);
    check_eq("rst_ovs", {22'b0, adc_oversample_out}, 32'h0FF);
    wb_read(RSTAT, rd); check_eq("rst_status", rd, 32'h0000_0100);
    wb_read(RCTRL, rd); check_eq("rst_ctrl", rd, 32'h00FF_0000);

    // Basic capture
    wb_write(RCTRL, 32'h0040_0001);
    check_eq("cap_ovs", {22'b0, adc_oversample_out}, 32'h040);
    check_eq("cap_en", {31'b0, adc_enable_out}, 32'd1);
    adc_push(32'hA1); adc_push(32'hB2); adc_push(32'hC3);
    wb_read(RSTAT, rd); check_eq("cap_status3", rd, 32'h0000_0803);
    wb_read(RDATA, rd); check_eq("cap_rd0", rd, 32'hA1);
    wb_read(RDATA, rd); check_eq("cap_rd1", rd, 32'hB2);
    wb_read(RDATA, rd); check_eq("cap_rd2", rd, 32'hC3);
    wb_read(RDATA, rd); check_eq("cap_rd_empty", rd, 32'h0);
    wb_read(RSTAT, rd); check_eq("cap_status_empty", rd, 32'h0000_0900);

    // Overflow: 10 pushes into a depth-8 FIFO
    for (int i = 1; i <= 10; i++) adc_push(32'(i));
    wb_read(RSTAT, rd); check_eq("ovf_status", rd, 32'h0000_0E08);
    for (int i = 1; i <= 8; i++) begin
      wb_read(RDATA, rd); check_eq("ovf_rd", rd, 32'(i));
    end
    wb_read(RSTAT, rd); check_eq("ovf_sticky", rd, 32'h0000_0D00);
    wb_write(RSTAT, 32'h0000_0400);
    wb_read(RSTAT, rd); check_eq("ovf_cleared", rd, 32'h0000_0900);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) adc_push(32'h11 + 32'(i));
    wb_xfer(1'b0, RDATA, 32'd0, 1'b1, 32'h99, rd);
    check_eq("fpp_rd", rd, 32'h11);
    wb_read(RSTAT, rd); check_eq("fpp_status", rd, 32'h0000_0A08);
    for (int i = 1; i < 8; i++) begin
      wb_read(RDATA, rd); check_eq("fpp_drain", rd, 32'h11 + 32'(i));
    end
    wb_read(RDATA, rd); check_eq("fpp_last", rd, 32'h99);

    // Threshold irq at 4
    wb_write(RCTRL, 32'h0040_0041);
    adc_push(32'h41); adc_push(32'h42); adc_push(32'h43);
    check_eq("irq_below", {31'b0, irq_o}, 32'd0);
    adc_push(32'h44);
    check_eq("irq_lag", {31'b0, irq_o}, 32'd0);
    @(posedge clk); #1;
    check_eq("irq_rise", {31'b0, irq_o}, 32'd1);
    wb_read(RDATA, rd); check_eq("irq_rd", rd, 32'h41);
    check_eq("irq_fall", {31'b0, irq_o}, 32'd0);
    for (int i = 0; i < 3; i++) wb_read(RDATA, rd);

    // Flush with a same-edge push
    for (int i = 0; i < 5; i++) adc_push(32'h51 + 32'(i));
    check_eq("flush_irq_pre", {31'b0, irq_o}, 32'd1);
    wb_xfer(1'b1, RCTRL, 32'h0040_0043, 1'b1, 32'h77, rd);
    wb_read(RSTAT, rd); check_eq("flush_status", rd, 32'h0000_0900);
    check_eq("flush_irq", {31'b0, irq_o}, 32'd0);
    wb_read(RCTRL, rd); check_eq("flush_ctrl", rd, 32'h0040_0041);

    // Disabled: pushes dropped, no overflow
    wb_write(RCTRL, 32'h0040_0040);
    for (int i = 0; i < 10; i++) adc_push(32'hD0 + 32'(i));
    wb_read(RSTAT, rd); check_eq("dis_status", rd, 32'h0000_0100);
    check_eq("dis_en", {31'b0, adc_enable_out}, 32'd0);

    // Reset asserted while ack is high
    wb_write(RCTRL, 32'h0040_0001);
    adc_push(32'hE1); adc_push(32'hE2);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = {RDATA, 2'b00};
    @(posedge clk); #1;
    check_eq("rma_ack", {31'b0, wbs_ack_o}, 32'd1);
    check_eq("rma_dat", wbs_dat_o, 32'hE1);
    rst_n = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge clk); #1;
    check_eq("rma_ack_drop", {31'b0, wbs_ack_o}, 32'd0);
    rst_n = 1'b1;
    wb_read(RSTAT, rd); check_eq("rma_status", rd, 32'h0000_0100);
    check_eq("rma_ovs", {22'b0, adc_oversample_out}, 32'h0FF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_sample_reader.md
Name: adc_sample_reader

Overview:
- Consumer end of the VCO-ADC output stream.
- Buffers `data_out`/`data_valid_out` samples in a small synchronous FIFO and drives the ADC's `enable_in` and `oversample_in` controls.
- Exposes samples, status and control to the Caravel management core through a Wishbone-classic slave (single-beat, registered ack).
- Raises a level interrupt when the buffer fill reaches a programmable threshold.

Parameters:
- DATA_WIDTH, 32, sample width; must match the ADC `data_out` width.
- DEPTH_LOG2, 3, log2 of FIFO depth (default depth 8).
- OVS_WIDTH, 10, oversample ratio width; must match the ADC `oversample_in` width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- adc_data_in  in  DATA_WIDTH  sample from the ADC.
- adc_valid_in  in  1  one-cycle strobe; sample is valid on this cycle.
- adc_enable_out  out  1  drives ADC `enable_in`.
- adc_oversample_out  out  OVS_WIDTH  drives ADC `oversample_in`.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_we_i  in  1  write enable.
- wbs_adr_i  in  4  byte address; only [3:2] are decoded.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- irq_o  out  1  fill-threshold interrupt, level.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO empty, count 0, overflow flag 0.
  - adc_enable_out=0, adc_oversample_out=10'h0FF, threshold 0.
  - wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
  - Reset mid-transaction aborts it: no ack, no pop.
- Wishbone handshake:
  - A request is cyc&stb with ack low. Request sampled at edge N gives ack=1 and wbs_dat_o valid during cycle N+1.
  - ack is high for exactly one cycle; it deasserts at N+2 even if stb is held.
  - A new request is accepted only on a cycle where ack is 0.
  - wbs_dat_o holds its last value when not acking.
- Register map (adr[3:2]):
  - 0 DATA
    - Read returns the FIFO head and pops it on the request edge.
    - Read when empty returns 0; no pop, count unchanged.
    - Write is ignored but acked.
  - 1 STATUS, read:
    - [DEPTH_LOG2:0] count.
    - [8] empty, [9] full, [10] overflow (sticky), [11] adc_enable_out.
    - Other bits read 0.
    - Write of 1 to bit 10 clears overflow; other write bits are ignored.
  - 2 CTRL, read/write:
    - [0] enable.
    - [1] flush: self-clearing, always reads 0. Writing 1 empties the FIFO on that edge.
    - [7:4] irq threshold.
    - [25:16] oversample.
    - Writes update all fields on the request edge.
  - 3 reserved: reads 0, writes ignored, still acked.
  - wbs_sel_i is not present; all writes are full-word.
- FIFO:
  - Depth 2^DEPTH_LOG2; count is DEPTH_LOG2+1 bits.
  - Push when adc_valid_in=1 and enable=1. Samples arriving while disabled are dropped and do not set overflow.
  - Full with push and no pop: sample dropped, overflow set, stored data untouched.
  - Full with push and pop on the same edge: both occur, count unchanged, no overflow.
  - Empty with push and pop on the same edge: the pop sees empty, so the read returns 0 and the push is stored.
  - Flush with push on the same edge: flush wins and the sample is discarded.
  - Flush with DATA pop on the same edge: cannot occur (single request per cycle).
  - Pointers wrap modulo depth.
- Overflow flag: if set and clear occur on the same edge, set wins.
- irq_o is registered: irq_o = (threshold != 0) && (count >= threshold), updated one cycle after the count changes.
- Clearing enable neither flushes the FIFO nor clears overflow. Stored samples stay readable.
- Oversample changes take effect on adc_oversample_out the cycle after the write edge. The ADC itself handles resynchronisation.

Decomposition:
- Shared package `adc_reader_pkg`:
  - Register offsets REG_DATA=0, REG_STATUS=1, REG_CTRL=2.
  - STATUS bit indices and CTRL field positions/widths.
  - Oversample reset constant 10'h0FF.
- One sub-module, `sync_fifo`: parameterised width/depth, push/pop/flush, count/full/empty outputs. It contains no overflow logic.
- The top level holds register decode, the Wishbone FSM (IDLE/ACK), and the overflow and irq logic.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then read STATUS -> 0x00000100 (empty). CTRL reads 0x00FF0000. adc_oversample_out=0x0FF, adc_enable_out=0.
- Basic capture: write CTRL=0x00400001, then push 3 samples 0xA1, 0xB2, 0xC3 -> STATUS count=3. Three DATA reads return A1, B2, C3. Fourth DATA read returns 0 and STATUS shows empty. adc_oversample_out=0x040.
- Overflow: enable, push 10 samples 1..10 -> count=8, full=1, overflow=1. Reads return 1..8. Writing STATUS=0x400 clears overflow.
- Full with simultaneous push and pop: fill to 8, issue a DATA read on the same edge as push 0x99 -> count stays 8, overflow=0, and 0x99 is returned last.
- Threshold irq: CTRL threshold=4 with enable. irq_o rises one cycle after the 4th push and falls one cycle after the pop that takes count to 3.
- Flush/disable: with 5 stored and a push on the flush edge -> count=0 afterwards. With enable=0, pushes are ignored and overflow stays 0. Reset asserted mid-ack -> ack=0 next cycle and FIFO empty.
